// File: rtl/mm_pkg.sv
// Shared types and sizes for the 4x4 systolic matmul job sequencer,
// aligners and PE array.
package mm_pkg;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int ROW_W = N * DW;
  localparam int BEATS = 2 * N;
  localparam int MAT_W = N * ROW_W;
  localparam int CW    = $clog2(BEATS);

  localparam int DRAIN_CYC_DEF    = 2 * N - 2;
  localparam int FEED_TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    FEED,
    DRAIN,
    CAPTURE,
    DONE
  } mm_state_t;

endpackage

// File: rtl/mm_seq_ctrl_if.sv
// Row-word load stream into the job sequencer (valid/ready).
// The host side is the master, the sequencer the slave.
interface mm_seq_ctrl_if;
  import mm_pkg::*;

  logic             valid;
  logic             ready;
  logic [ROW_W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/mm_row_bank.sv
// 2N-entry row register file; entries 0..N-1 form A, N..2N-1 form B,
// each presented packed with row 0 in the LSBs.
module mm_row_bank
  import mm_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [CW-1:0]    idx,
  input  logic [ROW_W-1:0] wdata,
  output logic [MAT_W-1:0] a_mat,
  output logic [MAT_W-1:0] b_mat
);

  logic [ROW_W-1:0] rows [BEATS];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < BEATS; i++) begin
        rows[i] <= '0;
      end
    end else if (we) begin
      rows[idx] <= wdata;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign a_mat[i*ROW_W +: ROW_W] = rows[i];
    assign b_mat[i*ROW_W +: ROW_W] = rows[N+i];
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Job sequencer: loads A/B rows, restarts the aligners, gates the PE
// array through feed and drain, then strobes capture and done.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int DRAIN_CYC    = DRAIN_CYC_DEF,
  parameter int FEED_TIMEOUT = FEED_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             st_rst,
  input  logic             start,
  mm_seq_ctrl_if.slave     ld,
  output logic [MAT_W-1:0] a_mat,
  output logic [MAT_W-1:0] b_mat,
  output logic             algn_rst,
  input  logic             algn_done_a,
  input  logic             algn_done_b,
  output logic             pe_clr,
  output logic             feed_en,
  output logic             res_capture,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int TMAX =
    (FEED_TIMEOUT > DRAIN_CYC) ? FEED_TIMEOUT : DRAIN_CYC;
  localparam int TW = $clog2(TMAX + 1);

  mm_state_t     state;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic          hs;
  logic          both;

  assign ld.ready = (state == LOAD);
  assign hs       = ld.valid && ld.ready;
  assign both     = algn_done_a && algn_done_b;

  // Row index equals the beat count: A rows then B rows.
  mm_row_bank u_bank (
    .clk   (clk),
    .clr   (st_rst),
    .we    (hs),
    .idx   (cnt),
    .wdata (ld.data),
    .a_mat (a_mat),
    .b_mat (b_mat)
  );

  always_ff @(posedge clk) begin
    if (st_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tcnt        <= '0;
      err         <= 1'b0;
      algn_rst    <= 1'b1;
      pe_clr      <= 1'b0;
      feed_en     <= 1'b0;
      res_capture <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      pe_clr      <= 1'b0;
      res_capture <= 1'b0;
      done        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            cnt   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (hs) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(BEATS - 1)) begin
              state  <= CLEAR;
              pe_clr <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state    <= FEED;
          tcnt     <= '0;
          algn_rst <= 1'b0;
          feed_en  <= 1'b1;
        end
        FEED: begin
          if (both) begin
            state    <= DRAIN;
            tcnt     <= '0;
            algn_rst <= 1'b1;
          end else if (tcnt == TW'(FEED_TIMEOUT - 1)) begin
            // Aligners hung: abort without loading results.
            state    <= DONE;
            err      <= 1'b1;
            algn_rst <= 1'b1;
            feed_en  <= 1'b0;
            done     <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        DRAIN: begin
          if (tcnt == TW'(DRAIN_CYC - 1)) begin
            state       <= CAPTURE;
            feed_en     <= 1'b0;
            res_capture <= 1'b1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        CAPTURE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Scoreboard bench for mm_seq_ctrl with behavioural aligner stand-ins.
// Jobs push expectations; a negedge monitor checks them on done.
module tb_mm_seq_ctrl;
  import mm_pkg::*;

  localparam int DRAIN = 6;
  localparam int TMO   = 15;
  localparam int NEVER = 100;

  logic             clk = 1'b0;
  logic             st_rst = 1'b1;
  logic             start = 1'b0;
  logic             algn_done_a = 1'b0;
  logic             algn_done_b = 1'b0;
  logic [MAT_W-1:0] a_mat;
  logic [MAT_W-1:0] b_mat;
  logic             algn_rst;
  logic             pe_clr;
  logic             feed_en;
  logic             res_capture;
  logic             busy;
  logic             done;
  logic             err;

  mm_seq_ctrl_if ld();

  mm_seq_ctrl dut (
    .clk         (clk),
    .st_rst      (st_rst),
    .start       (start),
    .ld          (ld),
    .a_mat       (a_mat),
    .b_mat       (b_mat),
    .algn_rst    (algn_rst),
    .algn_done_a (algn_done_a),
    .algn_done_b (algn_done_b),
    .pe_clr      (pe_clr),
    .feed_en     (feed_en),
    .res_capture (res_capture),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MAT_W-1:0] a;
    logic [MAT_W-1:0] b;
    logic             err;
    int               cap;
    int               lat;
    int               nfeed;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name,
                       input logic [MAT_W-1:0] act,
                       input logic [MAT_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Aligner stand-ins: done rises in FEED cycle la / lb and holds
  // until algn_rst returns.
  int la = NEVER;
  int lb = NEVER;
  int fcnt = 0;

  always @(posedge clk) begin
    #1;
    if (algn_rst) fcnt = 0;
    else fcnt++;
    algn_done_a = !algn_rst && (fcnt >= la);
    algn_done_b = !algn_rst && (fcnt >= lb);
  end

  // Monitor
  int   cyc = 0;
  int   nhs = 0, hs_cyc = 0;
  int   nclr = 0, clr_cyc = 0;
  int   nfeed = 0, ncap = 0, cap_cyc = 0;
  exp_t me;

  always @(negedge clk) begin
    cyc++;
    if (st_rst) begin
      nhs = 0; nclr = 0; nfeed = 0; ncap = 0;
    end else begin
      if (ld.valid && ld.ready) begin
        nhs++;
        hs_cyc = cyc;
      end
      if (pe_clr) begin
        nclr++;
        clr_cyc = cyc;
      end
      if (feed_en) nfeed++;
      if (res_capture) begin
        ncap++;
        cap_cyc = cyc;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: got done at cycle %0d want none",
                   cyc);
        end else begin
          me = sbq.pop_front();
          check("a_mat", a_mat, me.a);
          check("b_mat", b_mat, me.b);
          check("err", MAT_W'(err), MAT_W'(me.err));
          check("handshakes", MAT_W'(nhs), MAT_W'(BEATS));
          check("clear_pulses", MAT_W'(nclr), MAT_W'(1));
          check("clear_after_beat", MAT_W'(clr_cyc - hs_cyc), MAT_W'(1));
          check("latency", MAT_W'(cyc - hs_cyc), MAT_W'(me.lat));
          check("feed_cycles", MAT_W'(nfeed), MAT_W'(me.nfeed));
          check("captures", MAT_W'(ncap), MAT_W'(me.cap));
          if (me.cap == 1)
            check("capture_slot", MAT_W'(cap_cyc), MAT_W'(cyc - 1));
        end
        nhs = 0; nclr = 0; nfeed = 0; ncap = 0;
      end
    end
  end

  logic [ROW_W-1:0] rows [BEATS];

  task automatic rand_rows();
    for (int i = 0; i < BEATS; i++) rows[i] = ROW_W'($urandom);
  endtask

  // gap_mode: 0 back-to-back, 1 two idle cycles between beats, 2 random
  task automatic run_job(input int gap_mode, input int ta, input int tb,
                         input bit spur, input bit abort);
    exp_t e;
    int   t;
    int   g;
    int   bud;
    la = ta;
    lb = tb;
    for (int i = 0; i < N; i++) begin
      e.a[i*ROW_W +: ROW_W] = rows[i];
      e.b[i*ROW_W +: ROW_W] = rows[N+i];
    end
    t = (ta > tb) ? ta : tb;
    if (t <= TMO) begin
      e.err = 1'b0; e.cap = 1;
      e.nfeed = t + DRAIN;
      e.lat = 1 + t + DRAIN + 1 + 1;
    end else begin
      e.err = 1'b1; e.cap = 0;
      e.nfeed = TMO;
      e.lat = 1 + TMO + 1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_in_load", MAT_W'(busy), MAT_W'(1));
    check("err_clr_on_start", MAT_W'(err), MAT_W'(0));
    if (!abort) sbq.push_back(e);
    for (int k = 0; k < BEATS; k++) begin
      g = (gap_mode == 0) ? 0 :
          (gap_mode == 1) ? ((k == 0) ? 0 : 2) :
          int'($urandom_range(0, 3));
      ld.valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      ld.valid = 1'b1;
      ld.data  = rows[k];
      @(posedge clk); #1;
    end
    ld.valid = 1'b0;
    @(posedge clk); #1;
    if (spur) begin
      ld.valid = 1'b1;
      ld.data  = 32'hDEADBEEF;
      repeat (3) begin @(posedge clk); #1; end
      ld.valid = 1'b0;
    end
    if (abort) begin
      while (fcnt < 5) begin @(posedge clk); #1; end
      st_rst = 1'b1;
      start  = 1'b1;
      @(posedge clk); #1;
      st_rst = 1'b0;
      start  = 1'b0;
      @(negedge clk);
      check("rst_busy", MAT_W'(busy), MAT_W'(0));
      check("rst_algn_rst", MAT_W'(algn_rst), MAT_W'(1));
      check("rst_feed_en", MAT_W'(feed_en), MAT_W'(0));
      check("rst_a_mat", a_mat, '0);
      check("rst_b_mat", b_mat, '0);
      @(negedge clk);
      check("rst_start_ignored", MAT_W'(busy), MAT_W'(0));
      @(posedge clk); #1;
      return;
    end
    if (spur && !e.err) begin
      bud = 0;
      while (!(feed_en && algn_rst) && bud < 40) begin
        @(posedge clk); #1; bud++;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    bud = 0;
    while (!done && bud < 100) begin
      @(posedge clk); #1; bud++;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL done_timeout: got no done want done within 100");
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    ld.valid = 1'b0;
    ld.data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_algn_rst", MAT_W'(algn_rst), MAT_W'(1));
    check("reset_ready", MAT_W'(ld.ready), MAT_W'(0));
    check("reset_busy", MAT_W'(busy), MAT_W'(0));
    check("reset_done", MAT_W'(done), MAT_W'(0));
    check("reset_feed_en", MAT_W'(feed_en), MAT_W'(0));
    check("reset_pe_clr", MAT_W'(pe_clr), MAT_W'(0));
    check("reset_capture", MAT_W'(res_capture), MAT_W'(0));
    check("reset_err", MAT_W'(err), MAT_W'(0));
    check("reset_a_mat", a_mat, '0);
    st_rst = 1'b0;
    @(posedge clk); #1;

    rows[0] = 32'h04030201; rows[1] = 32'h08070605;
    rows[2] = 32'h0C0B0A09; rows[3] = 32'h100F0E0D;
    rows[4] = 32'h00000001; rows[5] = 32'h00000100;
    rows[6] = 32'h00010000; rows[7] = 32'h01000000;
    run_job(0, 11, 11, 1'b0, 1'b0);
    rand_rows();
    run_job(1, 11, 11, 1'b0, 1'b0);
    rand_rows();
    run_job(0, 8, 11, 1'b0, 1'b0);
    rand_rows();
    run_job(0, 11, NEVER, 1'b0, 1'b0);
    rand_rows();
    run_job(0, 11, 11, 1'b1, 1'b0);
    run_job(2, 15, 15, 1'b1, 1'b0);
    run_job(2, 16, 3, 1'b1, 1'b0);
    for (int j = 0; j < 20; j++) begin
      rand_rows();
      run_job(2, int'($urandom_range(1, 16)), int'($urandom_range(1, 16)),
              1'($urandom_range(0, 1)), 1'b0);
    end
    rand_rows();
    run_job(0, 11, 11, 1'b0, 1'b1);
    rand_rows();
    run_job(0, 11, 11, 1'b1, 1'b0);

    repeat (5) @(posedge clk);
    n_chk++;
    if (sbq.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d left want 0", sbq.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mm_seq_ctrl.md
Name: mm_seq_ctrl

Overview:
Job sequencer for the 4x4 8-bit systolic matrix multiplier. It collects A and B row words from a valid/ready stream and presents them as the A and B aligners' arr_in banks. It then restarts both aligners, gates the PE array during feed and drain, and pulses result capture and done. The block sits between the host/load interface and the aligner and systolic-array instances.

Parameters:
N, 4, matrix dimension (rows per operand; row word = N*DW bits)
DW, 8, element width
DRAIN_CYC, 6, cycles after both aligners finish until the last PE result is final (2*N-2)
FEED_TIMEOUT, 15, max FEED cycles before error abort

Ports:
clk  in  1  clock, all logic on rising edge
st_rst  in  1  synchronous active-high reset
start  in  1  begin a job; sampled only in IDLE
ld_valid  in  1  row word valid
ld_ready  out  1  row word accepted when ld_valid && ld_ready
ld_data  in  N*DW  row word; beats 0..N-1 = A rows 0..N-1, beats N..2N-1 = B rows 0..N-1
a_mat  out  N*N*DW  A rows packed, row 0 in LSBs; drives A aligner arr_in
b_mat  out  N*N*DW  B rows packed, row 0 in LSBs; drives B aligner arr_in
algn_rst  out  1  drives both aligners' st_rst
algn_done_a  in  1  A aligner done
algn_done_b  in  1  B aligner done
pe_clr  out  1  one-cycle accumulator clear to the array
feed_en  out  1  array PE enable (feed and drain)
res_capture  out  1  one-cycle result register load strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle job-complete pulse
err  out  1  sticky timeout flag; cleared by the next accepted start

Behaviour:
- Interface: one clock, clk; reset st_rst is synchronous and active-high.
- Reset (st_rst=1 at an edge, including mid-job): state=IDLE, beat count=0, a_mat=b_mat=0, err=0.
- Reset output values: algn_rst=1; ld_ready, pe_clr, feed_en, res_capture, busy and done all 0.
- States: IDLE, LOAD, CLEAR, FEED, DRAIN, CAPTURE, DONE. All outputs are Moore-registered from the state except ld_ready, which is combinational from the state.
- IDLE: algn_rst=1. start=1 -> LOAD, beat count=0, err<=0.
- LOAD: ld_ready=1. Each handshake writes ld_data to row (cnt mod N) of A (cnt<N) or B (cnt>=N), then cnt++. The handshake with cnt=2N-1 -> CLEAR. Gaps in ld_valid stall without limit.
- CLEAR: exactly 1 cycle; pe_clr=1, algn_rst=1 -> FEED.
- FEED: algn_rst=0, feed_en=1, timeout counter increments each cycle.
  - algn_done_a && algn_done_b sampled high -> DRAIN.
  - Counter reaching FEED_TIMEOUT with both dones not yet high -> err<=1, then DONE; CAPTURE is skipped.
  - Nominal FEED length is 11 cycles (aligner idle, store x2, send x7, stop).
  - The two dones need not rise together; wait for both.
- DRAIN: feed_en=1, algn_rst=1, and a_mat/b_mat are held. Runs exactly DRAIN_CYC cycles -> CAPTURE.
- CAPTURE: res_capture=1 and feed_en=0 for 1 cycle -> DONE.
- DONE: done=1 for 1 cycle -> IDLE.
- a_mat and b_mat change only on LOAD handshakes. They are stable from CLEAR through DONE, so the aligners' store state sees fixed data.
- Ignored inputs: start outside IDLE; ld_valid outside LOAD; algn_done_* outside FEED.
- Latency: from the last load handshake to the done pulse = 1 (CLEAR) + FEED + DRAIN_CYC + 1 + 1 cycles. Nominal value is 1+11+6+1+1 = 20.
- Back-to-back jobs: start asserted in the first IDLE cycle after DONE is accepted.

Decomposition:
- Package mm_pkg holds:
  - state enum mm_state_t (IDLE..DONE);
  - constants N, DW, ROW_W = N*DW, BEATS = 2*N;
  - DRAIN_CYC and FEED_TIMEOUT defaults.
- The aligners and the array pull N and DW from the same package.
- One sub-module, mm_row_bank: a 2N-entry row register file with write-enable, write index and packed a_mat/b_mat outputs, plus a clear. The FSM and counters stay in mm_seq_ctrl.

Test Plan:
- Nominal job: reset, then start. Load A rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D and B = identity rows 0x00000001, 0x00000100, 0x00010000, 0x01000000, back-to-back. Model aligners respond -> a_mat/b_mat match the packed rows, pe_clr is one pulse, feed_en is high for 11+6 cycles, res_capture then done pulses 20 cycles after the last beat, err=0.
- Stalled load: ld_valid toggled 1,0,0,1,... over the 8 beats -> exactly 8 handshakes accepted, rows are correct, and CLEAR is entered one cycle after the 8th.
- Staggered dones: algn_done_a rises 3 cycles before algn_done_b -> DRAIN starts the cycle after algn_done_b is seen, and the total latency grows by 0 relative to algn_done_b's timing.
- Timeout: algn_done_b held at 0 -> after 15 FEED cycles err=1 and done pulses, with no res_capture. The next start clears err.
- Reset mid-FEED: st_rst=1 for 1 cycle at FEED cycle 5 -> next cycle IDLE, algn_rst=1, busy=0, a_mat=b_mat=0. start during that reset is ignored.
- Spurious inputs: start pulsed in DRAIN, and ld_valid=1 with ld_data=0xDEADBEEF in FEED -> no state change and matrices unchanged.
